// File: rtl/row_word_sched_pkg.sv
// Shared constants and state type for the row-to-word scheduler.
// Defaults match the original 192b row split into 4 x 48b words.
package sched_pkg;
  localparam int DEF_WORD_W = 48;
  localparam int DEF_WORDS  = 4;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_t;
endpackage

// File: rtl/row_word_sched_word_mux.sv
// Combinational pick of word k from a row, MSB-first or LSB-first.
module word_mux #(
  parameter int WORD_W = 48,
  parameter int WORDS  = 4,
  localparam int ROW_W = WORD_W * WORDS,
  localparam int CNT_W = $clog2(WORDS)
) (
  input  logic [ROW_W-1:0]  i_row,
  input  logic              i_lsb_first,
  input  logic [CNT_W-1:0]  i_idx,
  output logic [WORD_W-1:0] o_word
);
  logic [CNT_W-1:0] w_slot;

  // MSB-first word k lives in slot WORDS-1-k counted from the LSB end.
  assign w_slot = i_lsb_first ? i_idx : (CNT_W'(WORDS - 1) - i_idx);
  assign o_word = i_row[w_slot * WORD_W +: WORD_W];
endmodule

// File: rtl/row_word_sched.sv
// Buffers one wide row and streams it out as WORDS narrow words, each tagged
// with a per-row address that advances when the last word of a row is taken.
module row_word_sched
  import sched_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int WORDS  = DEF_WORDS,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int ROW_W = WORD_W * WORDS,
  localparam int CNT_W = $clog2(WORDS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_lsb_first,
  input  logic              i_row_valid,
  output logic              o_row_ready,
  input  logic [ROW_W-1:0]  i_row_data,
  output logic              o_word_valid,
  input  logic              i_word_ready,
  output logic [WORD_W-1:0] o_word_data,
  output logic [CNT_W-1:0]  o_word_idx,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_word,
  output logic              o_row_done,
  output logic              o_addr_wrap
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  sched_state_t      r_state;
  logic              r_active;
  logic [ROW_W-1:0]  r_row;
  logic              r_lsb_first;
  logic [CNT_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_word;
  logic [ADDR_W-1:0] r_addr;
  logic              r_row_done;
  logic              r_addr_wrap;

  logic              w_word_valid;
  logic              w_last;
  logic              w_word_hs;
  logic              w_row_ready;
  logic              w_row_acc;
  logic [CNT_W-1:0]  w_idx_next;
  logic [WORD_W-1:0] w_first_word;
  logic [WORD_W-1:0] w_next_word;

  assign w_word_valid = (r_state == SEND);
  assign w_last       = w_word_valid && (r_idx == LAST_IDX);
  assign w_word_hs    = w_word_valid && i_word_ready;
  // r_active keeps row_ready low while reset is held without a combinational reset path.
  assign w_row_ready  = r_active && !i_start &&
                        ((r_state == IDLE) || (w_last && i_word_ready));
  assign w_row_acc    = i_row_valid && w_row_ready;
  assign w_idx_next   = r_idx + CNT_W'(1);

  // Word 0 of the incoming row is registered on the accept edge.
  word_mux #(.WORD_W(WORD_W), .WORDS(WORDS)) u_first (
    .i_row       (i_row_data),
    .i_lsb_first (i_lsb_first),
    .i_idx       ({CNT_W{1'b0}}),
    .o_word      (w_first_word)
  );

  word_mux #(.WORD_W(WORD_W), .WORDS(WORDS)) u_next (
    .i_row       (r_row),
    .i_lsb_first (r_lsb_first),
    .i_idx       (w_idx_next),
    .o_word      (w_next_word)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_active    <= 1'b0;
      r_row       <= '0;
      r_lsb_first <= 1'b0;
      r_idx       <= '0;
      r_word      <= '0;
      r_addr      <= '0;
      r_row_done  <= 1'b0;
      r_addr_wrap <= 1'b0;
    end else begin
      r_active    <= 1'b1;
      r_row_done  <= 1'b0;
      r_addr_wrap <= 1'b0;
      if (i_start) begin
        r_state <= IDLE;
        r_addr  <= i_base_addr;
        r_idx   <= '0;
        r_row   <= '0;
        r_word  <= '0;
      end else begin
        if (w_word_hs && w_last) begin
          r_row_done  <= 1'b1;
          r_addr      <= r_addr + ADDR_W'(1);
          r_addr_wrap <= &r_addr;
        end
        // A row can only be taken in SEND on the last-word handshake, so loading wins.
        if (w_row_acc) begin
          r_row       <= i_row_data;
          r_lsb_first <= i_lsb_first;
          r_idx       <= '0;
          r_word      <= w_first_word;
          r_state     <= SEND;
        end else if (w_word_hs) begin
          if (w_last) begin
            r_state <= IDLE;
          end else begin
            r_idx  <= w_idx_next;
            r_word <= w_next_word;
          end
        end
      end
    end
  end

  assign o_row_ready  = w_row_ready;
  assign o_word_valid = w_word_valid;
  assign o_word_data  = r_word;
  assign o_word_idx   = r_idx;
  assign o_addr       = r_addr;
  assign o_last_word  = w_last;
  assign o_row_done   = r_row_done;
  assign o_addr_wrap  = r_addr_wrap;
endmodule
